// File: rtl/mpc_constraint_vec_loader_pkg.sv
// Shared configuration for the constraint-vector loader: geometry, FSM states
// and the power-up contents that mimic the fixed constraint ROM.
package mpc_cfg_pkg;

  localparam int DATA_W = 17;
  localparam int ADDR_W = 3;
  localparam int N_ROWS = 6;

  localparam logic [DATA_W-1:0] INIT_EVEN = 17'h08000;
  localparam logic [DATA_W-1:0] INIT_ODD  = 17'h19220;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/mpc_constraint_vec_loader_if.sv
// Host stream, status and pipeline read port of the constraint-vector loader.
interface mpc_constraint_vec_loader_if;
  import mpc_cfg_pkg::*;

  logic              start;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              busy;
  logic              swap;
  logic              active_bank;
  logic [ADDR_W-1:0] address0;
  logic              ce0;
  logic [DATA_W-1:0] q0;

  modport master (
    output start, s_data, s_valid, address0, ce0,
    input  s_ready, busy, swap, active_bank, q0
  );

  modport slave (
    input  start, s_data, s_valid, address0, ce0,
    output s_ready, busy, swap, active_bank, q0
  );

endinterface

// File: rtl/mpc_constraint_vec_loader_ram.sv
// One constraint bank: single write port, registered read port; out-of-range
// reads return zero. Contents power up as the alternating ROM pattern.
module mpc_dp_ram_1w1r #(
  parameter int            DW        = 17,
  parameter int            AW        = 3,
  parameter int            DEPTH     = 6,
  parameter logic [DW-1:0] INIT_EVEN = {DW{1'b0}},
  parameter logic [DW-1:0] INIT_ODD  = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  typedef logic [DW-1:0] mem_t [DEPTH];

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = ((i % 2) == 0) ? INIT_EVEN : INIT_ODD;
    end
    return m;
  endfunction

  mem_t          mem_r = init_mem();
  logic [DW-1:0] rdata_r;

  // Write port; storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (we && (waddr <= LAST)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read, holds when not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DW{1'b0}};
    end else if (re) begin
      if (raddr <= LAST) begin
        rdata_r <= mem_r[raddr];
      end else begin
        rdata_r <= {DW{1'b0}};
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mpc_constraint_vec_loader.sv
// Ping-pong constraint-vector table: streams a new vector into the shadow bank
// while q0 serves the active bank, then swaps banks atomically.
module mpc_constraint_vec_loader
  import mpc_cfg_pkg::*;
(
  input logic                        clk,
  input logic                        reset,
  mpc_constraint_vec_loader_if.slave bus
);

  state_e            state_r, state_s;
  logic [ADDR_W-1:0] wr_cnt_r, wr_cnt_s;
  logic              s_ready_r;
  logic              busy_r;
  logic              swap_r;
  logic              active_bank_r;
  logic              rd_sel_r;
  logic              accept_s;
  logic              we_bank0_s;
  logic              we_bank1_s;
  logic [DATA_W-1:0] q_bank0_s;
  logic [DATA_W-1:0] q_bank1_s;

  assign accept_s   = s_ready_r & bus.s_valid;
  assign we_bank0_s = accept_s & active_bank_r;
  assign we_bank1_s = accept_s & ~active_bank_r;

  // Next-state and write-counter logic.
  always_comb begin
    state_s  = state_r;
    wr_cnt_s = wr_cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s  = LOAD;
          wr_cnt_s = {ADDR_W{1'b0}};
        end else begin
          state_s  = IDLE;
        end
      end
      LOAD: begin
        if (accept_s) begin
          if (wr_cnt_r == LAST_ROW) begin
            state_s  = COMMIT;
            wr_cnt_s = {ADDR_W{1'b0}};
          end else begin
            wr_cnt_s = wr_cnt_r + ADDR_W'(1);
          end
        end else begin
          wr_cnt_s = wr_cnt_r;
        end
      end
      COMMIT: begin
        state_s = IDLE;
      end
      default: begin
        state_s  = IDLE;
        wr_cnt_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, registered status flags and bank select.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      wr_cnt_r      <= {ADDR_W{1'b0}};
      s_ready_r     <= 1'b0;
      busy_r        <= 1'b0;
      swap_r        <= 1'b0;
      active_bank_r <= 1'b0;
      rd_sel_r      <= 1'b0;
    end else begin
      state_r   <= state_s;
      wr_cnt_r  <= wr_cnt_s;
      s_ready_r <= (state_s == LOAD);
      busy_r    <= (state_s != IDLE);
      swap_r    <= (state_r == COMMIT);
      if (state_r == COMMIT) begin
        active_bank_r <= ~active_bank_r;
      end
      // Bank choice is frozen with the read, so a toggle never retargets an issued read.
      if (bus.ce0) begin
        rd_sel_r <= active_bank_r;
      end
    end
  end

  mpc_dp_ram_1w1r #(
    .DW(DATA_W), .AW(ADDR_W), .DEPTH(N_ROWS), .INIT_EVEN(INIT_EVEN), .INIT_ODD(INIT_ODD)
  ) u_bank0 (
    .clk(clk), .rst_n(reset), .we(we_bank0_s), .waddr(wr_cnt_r), .wdata(bus.s_data),
    .re(bus.ce0), .raddr(bus.address0), .rdata(q_bank0_s)
  );

  mpc_dp_ram_1w1r #(
    .DW(DATA_W), .AW(ADDR_W), .DEPTH(N_ROWS), .INIT_EVEN(INIT_EVEN), .INIT_ODD(INIT_ODD)
  ) u_bank1 (
    .clk(clk), .rst_n(reset), .we(we_bank1_s), .waddr(wr_cnt_r), .wdata(bus.s_data),
    .re(bus.ce0), .raddr(bus.address0), .rdata(q_bank1_s)
  );

  assign bus.s_ready     = s_ready_r;
  assign bus.busy        = busy_r;
  assign bus.swap        = swap_r;
  assign bus.active_bank = active_bank_r;
  assign bus.q0          = rd_sel_r ? q_bank1_s : q_bank0_s;

endmodule
